field_unpack_seq: RTL
=====================

# field_unpack_seq

Sequential bit-field unpacker that feeds the indexed part-select extraction stage. It accepts one 32-bit word through a valid/ready handshake and then services a stream of field requests of width 1, 2, 4 or 8. Each request returns the next field from a cursor that walks LSB-first or MSB-first. When the word is exhausted or flushed, the block requests a new word.

## Interface
Parameters:
- WORD_W, 32, input word width (only 32 supported)
- ERR_CNT_W, 16, width of the error counter (used only with the macro below)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- word_valid  in  1  upstream word available
- word_ready  out  1  block can accept a word
- word_data  in  32  word to unpack
- word_dir  in  1  0 = up (LSB-first, +: select), 1 = down (MSB-first, -: select); latched with the word
- flush  in  1  synchronous discard of the held word and any pending output
- req_valid  in  1  field request present
- req_ready  out  1  request accepted this cycle when both are high
- req_width  in  4  requested field width; legal values 1, 2, 4, 8
- out_valid  out  1  field result valid
- out_ready  in  1  downstream accepts result
- out_data  out  8  extracted field, zero-extended at the MSB side
- out_last  out  1  this field consumed the final bits of the word
- out_err  out  1  request was illegal or exceeded the remaining bits
- err_count  out  ERR_CNT_W  saturating error count (present only with FIELD_UNPACK_ERR_CNT_EN)

## Operation
**States.**
- EMPTY: no word held.
- HOLD: word held; `rem` (6 bits, 1..32) holds the unread bit count.

**Reset and EMPTY.**
- Reset enters EMPTY with rem=0, out_valid=0, out_data=0, out_last=0, out_err=0, err_count=0.
- word_ready = (state==EMPTY). In EMPTY, req_ready=0.

**Word acceptance.**
- A word is accepted in EMPTY when word_valid=1.
- Latches word_data and word_dir, sets rem=32, moves to HOLD.

**Request acceptance.**
- req_ready = (state==HOLD) && (!out_valid || out_ready).

**Field extraction.**
- Start index: up uses idx = 32-rem with field word[idx +: w]; down uses idx = rem-1 with field word[idx -: w].
- Legal request with w ≤ rem:
  - out_data = field zero-extended to 8 bits.
  - rem -= w.
  - out_last = (rem becomes 0).
  - out_err = 0.
  - If rem reaches 0, the state goes to EMPTY.
- Illegal width (not 1/2/4/8), or w > rem:
  - out_data = 0, out_err = 1, out_last = 1.
  - The word is discarded (rem=0) and the state goes to EMPTY.

**Output register.**
- out_valid is set on request acceptance.
- out_valid is cleared on out_ready when no new request is accepted that cycle.
- out_data, out_last and out_err hold their values while out_valid && !out_ready.

**Flush.**
- flush=1 has priority over all other events.
- Next state is EMPTY, rem=0, out_valid=0; out_data, out_last and out_err are cleared to 0.
- Any word or request offered in a flush cycle is not accepted: word_ready and req_ready are forced low while flush=1.
- err_count is not cleared by flush.

## Timing
- A word accepted at edge N puts the block in HOLD after N. req_ready can be high in the cycle after N.
- A request accepted at edge M makes out_valid=1 after M, so request-to-result latency is 1 cycle.
- Back-to-back requests are accepted every cycle while out_ready=1: a result is consumed and the next one is loaded at the same edge.
- Last field at edge M: state is EMPTY after M and word_ready=1 in the cycle after M. The minimum word-to-word turnaround is 1 idle cycle after the final field.
- Reset mid-operation drops the held word and any pending result immediately (asynchronous).

## Configuration
- FIELD_UNPACK_ERR_CNT_EN defined:
  - err_count increments by 1 on every accepted request that produces out_err=1.
  - It saturates at all-ones and resets to 0 only via rst.
- FIELD_UNPACK_ERR_CNT_EN undefined: the err_count port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package field_unpack_pkg holds:
  - state_e (EMPTY, HOLD)
  - dir_e (DIR_UP, DIR_DOWN)
  - localparam WORD_W = 32
  - function width_legal(w) returning w ∈ {1,2,4,8}
- One sub-module, field_extract: a combinational mux taking the word, dir, idx and width and returning the 8-bit zero-extended field. The top level holds the FSM, cursor, handshakes and output register.

## Test plan
- **Up walk:** word 0xA5C3_1E7F, dir=0, widths 8,8,8,8 → out_data 0x7F, 0x1E, 0xC3, 0xA5; out_last only on the 4th field; word_ready=1 the next cycle.
- **Down walk:** same word, dir=1, widths 4,4,8 → 0xA, 0x5, 0xC3; rem=16 held; then flush → EMPTY, no output.
- **Overrun:** word 0xFFFF_FFFF, dir=0, widths 8,8,8,4,8 → fifth result out_data=0, out_err=1, out_last=1; with FIELD_UNPACK_ERR_CNT_EN, err_count=1.
- **Illegal width:** width 3 on a fresh word → out_err=1, out_data=0, word discarded.
- **Backpressure:** out_ready=0 for 3 cycles after the first result → req_ready=0, out_data stable; release → next request accepted the same cycle.
- **Async reset mid-word:** assert rst while rem=12 → out_valid=0, word_ready=1, err_count=0 immediately.

Source files
------------

// File: rtl/field_unpack_pkg.sv
// field_unpack_pkg
// Shared types and helpers for the field_unpack_seq bit-field unpacker.
//   state_e     : EMPTY (no word held) / HOLD (word held, bits remain)
//   dir_e       : DIR_UP (LSB-first walk) / DIR_DOWN (MSB-first walk)
//   WORD_W      : unpacked word width (only 32 is supported)
//   width_legal : true for the field widths 1, 2, 4 and 8
package field_unpack_pkg;

    localparam int WORD_W = 32;

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    function automatic logic width_legal(input logic [3:0] w);
        logic legal;
        case (w)
            4'd1, 4'd2, 4'd4, 4'd8: legal = 1'b1;
            default:                legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/field_extract.sv
// field_extract
// Combinational field selector for field_unpack_seq.
// Returns word[idx +: width] (up) or word[idx -: width] (down), zero-extended
// to 8 bits. Only meaningful for legal widths that fit below/above idx; the
// caller discards the result otherwise.
// Ports:
//   i_word  : word being unpacked
//   i_dir   : 0 = up (idx is the field LSB), 1 = down (idx is the field MSB)
//   i_idx   : cursor bit position
//   i_width : field width (1, 2, 4, 8)
//   o_field : extracted field, zero-extended at the MSB side
module field_extract
    import field_unpack_pkg::*;
(
    input  logic [WORD_W-1:0] i_word,
    input  logic              i_dir,
    input  logic [4:0]        i_idx,
    input  logic [3:0]        i_width,
    output logic [7:0]        o_field
);

    logic [5:0] w_lo;
    logic [7:0] w_raw;
    logic [7:0] w_mask;

    // Shift the field down to bit 0 and keep only the requested width
    always_comb begin
        w_lo   = 6'd0;
        w_raw  = 8'd0;
        w_mask = 8'd0;
        // For a down select idx is the MSB, so the field LSB sits width-1 below it
        if (i_dir == DIR_DOWN) begin
            w_lo = {1'b0, i_idx} + 6'd1 - {2'b00, i_width};
        end else begin
            w_lo = {1'b0, i_idx};
        end
        w_raw = 8'(i_word >> w_lo);
        if ((i_width == 4'd0) || (i_width > 4'd8)) begin
            w_mask = 8'h00;
        end else begin
            w_mask = 8'hFF >> (4'd8 - i_width);
        end
        o_field = w_raw & w_mask;
    end

endmodule

// File: rtl/field_unpack_seq.sv
// field_unpack_seq
// Sequential bit-field unpacker. Accepts one 32-bit word (valid/ready), then
// returns fields of width 1/2/4/8 from a cursor walking LSB-first (up) or
// MSB-first (down). Illegal widths or requests larger than the remaining bits
// return an error result and discard the word. flush clears everything except
// the error counter.
// Optional feature macro: FIELD_UNPACK_ERR_CNT_EN adds the saturating
// err_count output; without it the port and its logic are absent.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   word_valid/word_ready         : word handshake, word_data/word_dir latched
//   flush                         : synchronous discard, highest priority
//   req_valid/req_ready/req_width : field request handshake
//   out_valid/out_ready           : result handshake (registered output)
//   out_data/out_last/out_err     : field, final-bits flag, error flag
//   err_count                     : saturating error count (macro only)
module field_unpack_seq
    import field_unpack_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int ERR_CNT_W = 16
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  word_valid,
    output logic                  word_ready,
    input  logic [WORD_W-1:0]     word_data,
    input  logic                  word_dir,
    input  logic                  flush,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [3:0]            req_width,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0]            out_data,
    output logic                  out_last,
    output logic                  out_err
`ifdef FIELD_UNPACK_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0]  err_count
`endif
);

    state_e              r_state;
    logic [5:0]          r_rem;
    logic [WORD_W-1:0]   r_word;
    logic                r_dir;
    logic                r_out_valid;
    logic [7:0]          r_out_data;
    logic                r_out_last;
    logic                r_out_err;

    state_e              w_state_nxt;
    logic [5:0]          w_rem_nxt;
    logic [WORD_W-1:0]   w_word_nxt;
    logic                w_dir_nxt;
    logic                w_out_valid_nxt;
    logic [7:0]          w_out_data_nxt;
    logic                w_out_last_nxt;
    logic                w_out_err_nxt;
    logic                w_err_inc;

    logic                w_word_ready;
    logic                w_req_ready;
    logic                w_req_fire;
    logic                w_req_ok;
    logic [5:0]          w_rem_after;
    logic [4:0]          w_idx;
    logic [7:0]          w_field;

    // flush masks both acceptances so nothing is taken in a discard cycle
    assign w_word_ready = !flush && (r_state == EMPTY);
    assign w_req_ready  = !flush && (r_state == HOLD) && (!r_out_valid || out_ready);
    assign w_req_fire   = req_valid && w_req_ready;
    assign w_req_ok     = width_legal(req_width) && ({2'b00, req_width} <= r_rem);
    assign w_rem_after  = r_rem - {2'b00, req_width};

    // Cursor: up starts at 32-rem (field LSB), down at rem-1 (field MSB)
    always_comb begin
        w_idx = 5'd0;
        if (r_dir == DIR_DOWN) begin
            w_idx = 5'(r_rem - 6'd1);
        end else begin
            w_idx = 5'(6'd32 - r_rem);
        end
    end

    field_extract u_extract (
        .i_word  (r_word),
        .i_dir   (r_dir),
        .i_idx   (w_idx),
        .i_width (req_width),
        .o_field (w_field)
    );

    // Next-state, cursor and output-register update
    always_comb begin
        w_state_nxt     = r_state;
        w_rem_nxt       = r_rem;
        w_word_nxt      = r_word;
        w_dir_nxt       = r_dir;
        w_out_valid_nxt = r_out_valid;
        w_out_data_nxt  = r_out_data;
        w_out_last_nxt  = r_out_last;
        w_out_err_nxt   = r_out_err;
        w_err_inc       = 1'b0;

        if (flush) begin
            w_state_nxt     = EMPTY;
            w_rem_nxt       = 6'd0;
            w_out_valid_nxt = 1'b0;
            w_out_data_nxt  = 8'd0;
            w_out_last_nxt  = 1'b0;
            w_out_err_nxt   = 1'b0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (word_valid) begin
                        w_word_nxt  = word_data;
                        w_dir_nxt   = word_dir;
                        w_rem_nxt   = 6'd32;
                        w_state_nxt = HOLD;
                    end else begin
                        w_state_nxt = EMPTY;
                    end
                end
                HOLD: begin
                    if (w_req_fire) begin
                        if (w_req_ok) begin
                            w_out_data_nxt = w_field;
                            w_rem_nxt      = w_rem_after;
                            w_out_last_nxt = (w_rem_after == 6'd0);
                            w_out_err_nxt  = 1'b0;
                            if (w_rem_after == 6'd0) begin
                                w_state_nxt = EMPTY;
                            end else begin
                                w_state_nxt = HOLD;
                            end
                        end else begin
                            // Bad request: report it and drop the rest of the word
                            w_out_data_nxt = 8'd0;
                            w_out_last_nxt = 1'b1;
                            w_out_err_nxt  = 1'b1;
                            w_rem_nxt      = 6'd0;
                            w_state_nxt    = EMPTY;
                            w_err_inc      = 1'b1;
                        end
                    end else begin
                        w_state_nxt = HOLD;
                    end
                end
                default: begin
                    w_state_nxt = EMPTY;
                    w_rem_nxt   = 6'd0;
                end
            endcase

            // A consumed result is replaced in the same edge by a new one
            if (w_req_fire) begin
                w_out_valid_nxt = 1'b1;
            end else if (out_ready) begin
                w_out_valid_nxt = 1'b0;
            end else begin
                w_out_valid_nxt = r_out_valid;
            end
        end
    end

    // State, cursor, held word and output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= EMPTY;
            r_rem       <= 6'd0;
            r_word      <= {WORD_W{1'b0}};
            r_dir       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'd0;
            r_out_last  <= 1'b0;
            r_out_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rem       <= w_rem_nxt;
            r_word      <= w_word_nxt;
            r_dir       <= w_dir_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_last  <= w_out_last_nxt;
            r_out_err   <= w_out_err_nxt;
        end
    end

`ifdef FIELD_UNPACK_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] r_err_count;

    // Saturating error counter, survives flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_count <= {ERR_CNT_W{1'b0}};
        end else if (w_err_inc && (r_err_count != {ERR_CNT_W{1'b1}})) begin
            r_err_count <= r_err_count + ERR_CNT_W'(1);
        end else begin
            r_err_count <= r_err_count;
        end
    end

    assign err_count = r_err_count;
`else
    logic [ERR_CNT_W-1:0] w_unused_err_cnt;
    assign w_unused_err_cnt = {ERR_CNT_W{w_err_inc}};
`endif

    assign word_ready = w_word_ready;
    assign req_ready  = w_req_ready;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_last   = r_out_last;
    assign out_err    = r_out_err;

endmodule
